// File: rtl/eforth_mbarb.sv
// Round-robin arbiter sharing one byte-wide synchronous memory between the eForth requesters.
// Grants are combinational and zero-latency; a lock holds ownership for up to MAXBURST bytes.
module eforth_mbarb #(
  parameter int ASZ      = 17,
  parameter int DSZ      = 8,
  parameter int NREQ     = 3,
  parameter int MAXBURST = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ASZ-1:0]      addr,
  input  logic [NREQ*DSZ-1:0]      wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DSZ-1:0]           rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ASZ-1:0]           mem_addr,
  output logic [DSZ-1:0]           mem_wdata,
  input  logic [DSZ-1:0]           mem_rdata,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int IW  = $clog2(NREQ);
  localparam int BCW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [BCW-1:0]  bc_q, bc_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   win, cand;
  logic            hit;
  logic            rd_vld_q;
  logic [IW-1:0]   rd_tag_q;

  // Grants are gated by rst_n so every output drops as soon as reset asserts.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    bc_d    = bc_q;
    own_d   = own_q;
    gnt     = '0;
    win     = '0;
    cand    = '0;
    hit     = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_q) + k) % NREQ);
            if (!hit && req[cand]) begin
              hit = 1'b1;
              win = cand;
            end
          end
          if (hit) begin
            gnt[win] = 1'b1;
            rr_d     = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            own_d    = win;
            if (lock[win]) begin
              state_d = LOCKED;
              bc_d    = BCW'(1);
            end
          end
        end
        LOCKED: begin
          // rr already points past the owner, so a forced release lets others in first.
          if (bc_q >= BCW'(MAXBURST)) begin
            state_d = IDLE;
          end else if (req[own_q]) begin
            hit        = 1'b1;
            win        = own_q;
            gnt[own_q] = 1'b1;
            if (lock[own_q]) bc_d = bc_q + 1'b1;
            else             state_d = IDLE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = hit;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (hit) begin
      mem_we    = we[win];
      mem_addr  = addr[int'(win)*ASZ +: ASZ];
      mem_wdata = wdata[int'(win)*DSZ +: DSZ];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      bc_q     <= '0;
      own_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      bc_q     <= bc_d;
      own_q    <= own_d;
      rd_vld_q <= hit & ~we[win];
      rd_tag_q <= win;
    end
  end

  assign rvalid = rd_vld_q ? ({{(NREQ-1){1'b0}}, 1'b1} << rd_tag_q) : '0;
  assign rdata  = rd_vld_q ? mem_rdata : '0;
  assign owner  = own_q;

endmodule

// File: tb/tb_eforth_mbarb.sv
// Directed bench for eforth_mbarb with a write-first byte memory model behind it.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_eforth_mbarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, lock, we;
  logic [50:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [1:0]  owner;

  logic [7:0]  mem [0:131071];
  logic [7:0]  rrd [0:2];
  int ncmp  = 0;
  int nfail = 0;

  eforth_mbarb #(.ASZ(17), .DSZ(8), .NREQ(3), .MAXBURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic setr(input int i, input logic r, input logic l, input logic w,
                      input logic [16:0] a, input logic [7:0] d);
    req[i]            = r;
    lock[i]           = l;
    we[i]             = w;
    addr[i*17 +: 17]  = a;
    wdata[i*8 +: 8]   = d;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rrd[0] = 8'h3A; rrd[1] = 8'h55; rrd[2] = 8'h77;
    rst_n = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    nxt(); nxt(); #1;
    chk("rst_gnt", gnt, 0);       chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);   chk("rst_owner", owner, 0);
    nxt(); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      nxt(); #1 chk("idle_mem_en", mem_en, 0);
    end

    // write 0x3A to 0x100, then read it back
    nxt(); setr(0, 1, 0, 1, 17'h00100, 8'h3A); #1;
    chk("w0_gnt", gnt, 3'b001); chk("w0_we", mem_we, 1); chk("w0_wdata", mem_wdata, 8'h3A);
    nxt(); setr(0, 1, 0, 0, 17'h00100, 8'h00); #1;
    chk("rd_gnt", gnt, 3'b001); chk("rd_addr", mem_addr, 17'h00100); chk("rd_we", mem_we, 0);
    nxt(); setr(0, 0, 0, 0, 17'h0, 8'h0); #1;
    chk("rd_rvalid", rvalid, 3'b001); chk("rd_rdata", rdata, 8'h3A);
    chk("rd_gnt_off", gnt, 0); chk("rd_owner", owner, 0);

    nxt(); setr(2, 1, 0, 1, 17'h00300, 8'h55); #1;
    chk("w2_gnt", gnt, 3'b100); chk("w2_we", mem_we, 1);
    chk("w2_addr", mem_addr, 17'h00300); chk("w2_wdata", mem_wdata, 8'h55);
    nxt(); setr(2, 0, 0, 0, 17'h0, 8'h0); setr(1, 1, 0, 0, 17'h00300, 8'h00); #1;
    chk("raw_gnt", gnt, 3'b010);
    // write from 0 and read from 2 collide; rr points at 2
    nxt(); setr(1, 0, 0, 0, 17'h0, 8'h0);
    setr(0, 1, 0, 1, 17'h00301, 8'h77); setr(2, 1, 0, 0, 17'h00100, 8'h00); #1;
    chk("raw_rvalid", rvalid, 3'b010); chk("raw_rdata", rdata, 8'h55);
    chk("col_gnt", gnt, 3'b100); chk("col_we", mem_we, 0); chk("col_addr", mem_addr, 17'h00100);
    nxt(); setr(2, 0, 0, 0, 17'h0, 8'h0); #1;
    chk("col_rvalid", rvalid, 3'b100); chk("col_rdata", rdata, 8'h3A);
    chk("col_gnt0", gnt, 3'b001); chk("col_wdata", mem_wdata, 8'h77);
    nxt(); setr(0, 0, 0, 0, 17'h0, 8'h0); setr(2, 1, 0, 0, 17'h00301, 8'h00); #1;
    chk("r301_gnt", gnt, 3'b100); chk("w_no_rvalid", rvalid, 0);
    nxt();
    setr(0, 1, 0, 0, 17'h00100, 8'h0); setr(1, 1, 0, 0, 17'h00300, 8'h0);
    setr(2, 1, 0, 0, 17'h00301, 8'h0); #1;
    chk("r301_rvalid", rvalid, 3'b100); chk("r301_rdata", rdata, 8'h77);

    // all three requesting: strict rotation 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      if (k > 0) nxt();
      #1 chk("rr_gnt", gnt, 32'(3'b001 << (k % 3)));
      if (k > 0) begin
        chk("rr_rvalid", rvalid, 32'(3'b001 << ((k - 1) % 3)));
        chk("rr_rdata", rdata, rrd[(k - 1) % 3]);
      end
    end
    nxt(); req = '0; #1;
    chk("rr_last_rvalid", rvalid, 3'b100); chk("rr_last_rdata", rdata, 8'h77);

    // locked 4-byte write burst from 0 while 1 waits
    setr(1, 1, 0, 0, 17'h00202, 8'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) nxt();
      setr(0, 1, (c < 3), 1, 17'(17'h00200 + c), 8'(8'h11 * (c + 1))); #1;
      chk("bl_gnt", gnt, 3'b001); chk("bl_addr", mem_addr, 32'(17'h00200 + c));
    end
    nxt(); setr(0, 0, 0, 0, 17'h0, 8'h0); #1;
    chk("bl_gnt1", gnt, 3'b010); chk("bl_addr1", mem_addr, 17'h00202);
    nxt(); setr(1, 0, 0, 0, 17'h0, 8'h0); #1;
    chk("bl_rvalid", rvalid, 3'b010); chk("bl_rdata", rdata, 8'h33); chk("bl_owner", owner, 1);

    // requester 2 holds lock past MAXBURST while 0 waits
    setr(0, 1, 0, 0, 17'h00200, 8'h0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) nxt();
      setr(2, 1, 1, 1, 17'(17'h00400 + k), 8'(k)); #1;
      chk("fr_gnt", gnt, 3'b100);
      if (k > 0) chk("fr_rvalid", rvalid, 0);
    end
    nxt(); #1;
    chk("fr_release_gnt", gnt, 0); chk("fr_release_en", mem_en, 0); chk("fr_owner", owner, 2);
    nxt(); #1;
    chk("fr_gnt0", gnt, 3'b001); chk("fr_addr0", mem_addr, 17'h00200);
    nxt(); req = '0; lock = '0; #1;
    chk("fr_rvalid0", rvalid, 3'b001); chk("fr_rdata0", rdata, 8'h11);

    nxt(); setr(1, 1, 0, 1, 17'h01400, 8'hC5); #1;
    chk("w1400_gnt", gnt, 3'b010);
    // read granted, then reset arrives before the data returns
    nxt(); setr(1, 1, 0, 0, 17'h01400, 8'h0); #1;
    chk("mr_gnt", gnt, 3'b010);
    #2 rst_n = 1'b0; #1;
    chk("mr_async_gnt", gnt, 0); chk("mr_async_en", mem_en, 0);
    chk("mr_async_owner", owner, 0); chk("mr_async_rvalid", rvalid, 0);
    nxt(); #1;
    chk("mr_no_rvalid", rvalid, 0); chk("mr_no_rdata", rdata, 0);
    rst_n = 1'b1; #1;
    chk("mr_regnt", gnt, 3'b010); chk("mr_readdr", mem_addr, 17'h01400);
    nxt(); req = '0; #1;
    chk("mr_rvalid", rvalid, 3'b010); chk("mr_rdata", rdata, 8'hC5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
